// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op and state encodings,
// default latencies and the busy-counter width helper.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Counter must hold the longer of the two latencies.
  function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(longest + 1);
  endfunction

  localparam int MD_CNT_W = md_cnt_width(MD_MULT_CYCLES_DEF, MD_DIV_CYCLES_DEF);

endpackage

// File: rtl/md_if.sv
// E-stage to multiply/divide unit bundle; the pipeline side is the master,
// the sequencer is the slave.
interface md_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_is_md;
  logic        flush;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, d_is_md, flush,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, d_is_md, flush,
    output busy, md_stall, hi, lo
  );

endinterface

// File: rtl/md_datapath.sv
// Combinational multiply/divide: yields the {hi,lo} pair an accepted op will
// eventually commit, plus a divide-by-zero flag.
module md_datapath
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_by_zero_o
);

  logic        is_signed;
  logic        is_div;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic [31:0] divisor;
  logic [31:0] sq, sr, uq, ur;

  assign is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign is_div    = (op_i == MD_DIV)  || (op_i == MD_DIVU);

  // Sign/zero extension lets one 64-bit multiplier serve MULT and MULTU.
  assign a_ext   = is_signed ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
  assign b_ext   = is_signed ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
  assign product = a_ext * b_ext;

  // A zero divisor is replaced so the dividers never produce X; the result is discarded.
  assign divisor = (b_i == 32'd0) ? 32'd1 : b_i;
  assign sq = 32'($signed(a_i) / $signed(divisor));
  assign sr = 32'($signed(a_i) % $signed(divisor));
  assign uq = a_i / divisor;
  assign ur = a_i % divisor;

  always_comb begin
    hi_o = product[63:32];
    lo_o = product[31:0];
    if (is_div) begin
      hi_o = is_signed ? sr : ur;
      lo_o = is_signed ? sq : uq;
    end
  end

  assign div_by_zero_o = is_div && (b_i == 32'd0);

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: accepts md ops from E, models latency with a busy
// counter, owns HI/LO and raises md_stall. MD_CANCEL_EN enables flush.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset_n,
  md_if.slave bus
);

  localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        commit_q, commit_d;

  logic [31:0] dp_hi, dp_lo;
  logic        dp_div_by_zero;
  logic        is_md_op;
  logic        is_div_op;
  logic        cancel;
  logic        busy;

  md_datapath u_datapath (
    .op_i          (bus.op),
    .a_i           (bus.src_a),
    .b_i           (bus.src_b),
    .hi_o          (dp_hi),
    .lo_o          (dp_lo),
    .div_by_zero_o (dp_div_by_zero)
  );

`ifdef MD_CANCEL_EN
  assign cancel = bus.flush;
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign cancel       = 1'b0;
`endif

  assign is_md_op  = bus.start && (bus.op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
  assign is_div_op = (bus.op == MD_DIV) || (bus.op == MD_DIVU);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    commit_d  = commit_q;
    case (state_q)
      MD_IDLE: begin
        if (bus.start && !cancel) begin
          if (is_md_op) begin
            state_d   = MD_RUN;
            cnt_d     = is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_hi_d = dp_hi;
            pend_lo_d = dp_lo;
            commit_d  = !dp_div_by_zero;
          end else if (bus.op == MD_MTHI) begin
            hi_d = bus.src_a;
          end else if (bus.op == MD_MTLO) begin
            lo_d = bus.src_a;
          end
        end
      end
      MD_RUN: begin
        // Starts arriving here are protocol violations and are ignored.
        if (cancel) begin
          state_d  = MD_IDLE;
          cnt_d    = '0;
          commit_d = 1'b0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d  = MD_IDLE;
          cnt_d    = '0;
          commit_d = 1'b0;
          if (commit_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      commit_q  <= commit_d;
    end
  end

  // Stall covers the accept cycle too, so a dependent D-stage op waits from the start.
  assign busy         = (state_q == MD_RUN);
  assign bus.busy     = busy;
  assign bus.md_stall = bus.d_is_md && (busy || is_md_op);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases then random ops against a
// sign/magnitude arithmetic model. Define MD_CANCEL_EN to exercise flush.
module tb_md_sequencer;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset_n;
  md_if bus ();

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Reference {hi,lo} from the architectural rules using unsigned magnitudes.
  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    logic [31:0] q, r;
    case (op)
      3'd0: begin
        prod = {32'b0, magnitude(a)} * {32'b0, magnitude(b)};
        return (a[31] ^ b[31]) ? (~prod + 64'd1) : prod;
      end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        q = magnitude(a) / magnitude(b);
        r = magnitude(a) % magnitude(b);
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31]) r = ~r + 32'd1;
        return {r, q};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_hi"}, bus.hi, expHi);
    checkOutput({tag, "_lo"}, bus.lo, expLo);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic dIsMd);
    logic isMd;
    int   n;
    isMd = (op <= 3'd3);
    checkOutput("no_start_while_busy", {31'b0, bus.busy}, 32'd0);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.src_a   = a;
    bus.src_b   = b;
    bus.d_is_md = dIsMd;
    #1;
    checkOutput("md_stall_accept", {31'b0, bus.md_stall}, {31'b0, dIsMd && isMd});
    nextCycle();
    bus.start = 1'b0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    #1;
    if (isMd) begin
      n = (op >= 3'd2) ? DIV_N : MULT_N;
      for (int i = 0; i < n; i++) begin
        checkOutput("busy_run", {31'b0, bus.busy}, 32'd1);
        checkOutput("md_stall_run", {31'b0, bus.md_stall}, {31'b0, dIsMd});
        checkRegs("hold_run");
        nextCycle();
      end
      if (!(op >= 3'd2 && b == 32'd0)) {expHi, expLo} = refResult(op, a, b);
    end else if (op == 3'd4) begin
      expHi = a;
    end else if (op == 3'd5) begin
      expLo = a;
    end
    checkOutput("busy_done", {31'b0, bus.busy}, 32'd0);
    checkOutput("md_stall_done", {31'b0, bus.md_stall}, 32'd0);
    checkRegs("result");
    bus.d_is_md = 1'b0;
  endtask

  initial begin
    logic [2:0]  rOp;
    logic [31:0] rA, rB;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 3'd0;
    bus.src_a   = 32'd0;
    bus.src_b   = 32'd0;
    bus.d_is_md = 1'b0;
    bus.flush   = 1'b0;
    #3;
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("reset_stall", {31'b0, bus.md_stall}, 32'd0);
    checkRegs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    nextCycle();

    applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    checkOutput("mult_neg3x5_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("mult_neg3x5_lo", bus.lo, 32'hFFFF_FFF1);
    applyStimulus(3'd3, 32'd7, 32'd2, 1'b0);
    checkOutput("divu_7_2_hi", bus.hi, 32'd1);
    checkOutput("divu_7_2_lo", bus.lo, 32'd3);
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checkOutput("div_neg7_2_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("div_neg7_2_lo", bus.lo, 32'hFFFF_FFFD);

    applyStimulus(3'd4, 32'h12, 32'd0, 1'b0);
    applyStimulus(3'd5, 32'h34, 32'd0, 1'b0);
    applyStimulus(3'd2, 32'd99, 32'd0, 1'b0);
    checkOutput("divzero_hi", bus.hi, 32'h12);
    checkOutput("divzero_lo", bus.lo, 32'h34);

    applyStimulus(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
    checkOutput("mthi_hi", bus.hi, 32'hDEAD_BEEF);
    applyStimulus(3'd6, 32'h5555_5555, 32'd3, 1'b1);
    applyStimulus(3'd0, 32'h0001_2345, 32'h0006_7890, 1'b1);

    // Reset asserted in the third busy cycle of a DIVU.
    bus.start = 1'b1; bus.op = 3'd3; bus.src_a = 32'd100; bus.src_b = 32'd7;
    nextCycle();
    bus.start = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("divu_pre_reset_busy", {31'b0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    expHi = 32'd0;
    expLo = 32'd0;
    checkOutput("midrun_reset_busy", {31'b0, bus.busy}, 32'd0);
    checkRegs("midrun_reset");
    @(negedge clk);
    reset_n = 1'b1;
    nextCycle();
    checkOutput("post_reset_busy", {31'b0, bus.busy}, 32'd0);

`ifdef MD_CANCEL_EN
    applyStimulus(3'd5, 32'hCAFE_0001, 32'd0, 1'b0);
    bus.start = 1'b1; bus.op = 3'd0; bus.src_a = 32'd3; bus.src_b = 32'd4;
    nextCycle();
    bus.start = 1'b0;
    nextCycle();
    bus.flush = 1'b1;
    nextCycle();
    bus.flush = 1'b0;
    checkOutput("cancel_busy", {31'b0, bus.busy}, 32'd0);
    checkRegs("cancel");
    for (int i = 0; i < MULT_N; i++) nextCycle();
    checkRegs("cancel_later");
    bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'h7777_7777; bus.flush = 1'b1;
    nextCycle();
    bus.start = 1'b0; bus.flush = 1'b0;
    checkOutput("flush_mthi_busy", {31'b0, bus.busy}, 32'd0);
    checkRegs("flush_mthi");
`else
    bus.flush = 1'b1;
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    bus.flush = 1'b0;
`endif

    for (int k = 0; k < 20; k++) begin
      rOp = 3'($urandom_range(0, 7));
      rA  = ($urandom_range(0, 3) == 0) ? (32'd0 - 32'($urandom_range(1, 50))) : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       rB = 32'd0;
        1:       rB = 32'($urandom_range(1, 9));
        2:       rB = 32'd0 - 32'($urandom_range(1, 9));
        default: rB = 32'($urandom);
      endcase
      applyStimulus(rOp, rA, rB, 1'($urandom_range(0, 1)));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) nextCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
